pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Reset sequencer and lock monitor on the consuming side of the system PLL's `rst`/`locked` handshake. Runs on the 50 MHz PLL reference clock and drives the PLL reset. It waits for a debounced lock and holds the core reset until the derived clocks (6/24/25 MHz) have settled. On lock loss or lock timeout it re-pulses the PLL reset, and it latches a fault after a bounded number of failed attempts.

## Interface
- `RST_PULSE`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 50000: cycles allowed from `pll_rst` release to a debounced lock (≥2).
- `LOCK_STABLE`, 256: consecutive synchronized-high `pll_locked` cycles required to accept lock (≥1).
- `HOLD_CYCLES`, 1000: cycles `core_reset` stays high after lock is accepted (≥1).
- `MAX_RETRIES`, 3: re-pulses allowed after the first attempt before fault (0–15).

Ports:
- `refclk` in 1: 50 MHz reference clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL lock; asynchronous to `refclk`.
- `pll_rst` out 1: PLL reset request, registered.
- `core_reset` out 1: downstream core reset, registered, active-high.
- `ready` out 1: high only in RUN.
- `fault` out 1: sticky; lock never achieved within the allowed retries.
- `lock_lost` out 1: sticky; lock dropped while in RUN.
- `retry_count` out 4: re-pulses issued in the current bring-up.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (reset to 0). The FSM sees only `locked_s`.
- States:
  - PULSE: `pll_rst`=1. After `RST_PULSE` cycles, go to WAIT_LOCK. Clear the timeout counter on entry.
  - WAIT_LOCK: `pll_rst`=0, timeout counter runs. If `locked_s`=1, go to STABLE with the stable counter cleared. If the counter reaches `LOCK_TIMEOUT`, go to RETRY.
  - STABLE: timeout counter keeps running; stable counter counts cycles with `locked_s`=1. If `locked_s`=0, go back to WAIT_LOCK without clearing the timeout counter. After `LOCK_STABLE` cycles, go to HOLD. A timeout here also goes to RETRY.
  - RETRY (single-cycle decision, folded into the transition): if `retry_count`==`MAX_RETRIES`, go to FAULT. Otherwise increment `retry_count` and go to PULSE.
  - HOLD: `core_reset` held. After `HOLD_CYCLES` cycles, go to RUN. If `locked_s`=0, go to PULSE; `retry_count` is unchanged and `lock_lost` is not set.
  - RUN: `core_reset`=0, `ready`=1. If `locked_s`=0, go to PULSE, set `lock_lost`, and clear `retry_count`.
  - FAULT: `pll_rst`=0, `core_reset`=1, `fault`=1. Exit only via `rst`.
- Outputs are decoded from the next state and registered, so an output changes on the same edge as its state.
- Counters are sized with `$clog2` of their parameter + 1. No wrap-around is possible because every counter is cleared on state entry.

## Timing
- While `rst`=1: state is PULSE with all counters 0. Outputs: `pll_rst`=1, `core_reset`=1, `ready`=0, `fault`=0, `lock_lost`=0, `retry_count`=0.
- `rst` takes priority over every event. Reset mid-sequence restarts from PULSE on the next cycle.
- With edge 0 as the first edge where `rst`=0:
  - `pll_rst` is high for edges 0..`RST_PULSE`-1.
  - `pll_rst` falls at edge `RST_PULSE`.
- Lock path latency: if edge e0 is the first edge sampling `pll_locked`=1 and it stays high, `core_reset` falls and `ready` rises at edge e0+2+`LOCK_STABLE`+`HOLD_CYCLES`.
- Lock loss in RUN: `locked_s` falls 2 edges after the drop. On the next edge, `core_reset`=1, `ready`=0, `pll_rst`=1 and `lock_lost`=1 are all set together.
- Each failed attempt lasts `RST_PULSE`+`LOCK_TIMEOUT` cycles.
- `fault` rises (`MAX_RETRIES`+1)×(`RST_PULSE`+`LOCK_TIMEOUT`) cycles after `rst` release.
- `pll_locked` glitches shorter than 1 cycle may or may not be seen. Any seen glitch in STABLE restarts debounce and is not counted as a retry.

## Test plan
Bench parameters: `RST_PULSE`=4, `LOCK_TIMEOUT`=32, `LOCK_STABLE`=8, `HOLD_CYCLES`=16, `MAX_RETRIES`=2.
- Clean bring-up: release `rst`, raise `pll_locked` at cycle 10 → `pll_rst` high for cycles 0–3; `core_reset` falls and `ready` rises at cycle 36; `retry_count`=0.
- Never locks: `pll_locked`=0 throughout → three `pll_rst` pulses at cycles 0, 36, 72; `retry_count` ends at 2; `fault`=1 at cycle 108 and stays; `core_reset` stays 1.
- Debounce: `pll_locked` high 5 cycles, low 1 cycle, then high → no HOLD entry until 8 consecutive synchronized-high cycles; `retry_count` stays 0.
- Lock loss in RUN: drop `pll_locked` at cycle 60 → at cycle 63 `core_reset`=1, `ready`=0, `pll_rst`=1, `lock_lost`=1. Relock → `ready` returns and `lock_lost` stays 1.
- Loss during HOLD: drop `pll_locked` mid-HOLD → re-pulse of `pll_rst`; `lock_lost`=0 and `retry_count` unchanged.
- Mid-sequence reset: assert `rst` for 1 cycle during STABLE and again in FAULT → all outputs return to their reset values and the sequence restarts from PULSE.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// Reset sequencer and lock monitor for the system PLL: pulses the PLL reset,
// debounces lock, holds the core reset while clocks settle, tracks faults.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE    = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned HOLD_CYCLES  = 1000,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  localparam int unsigned PW = $clog2(RST_PULSE + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_PULSE,
    S_WAIT,
    S_STABLE,
    S_HOLD,
    S_RUN,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, locked_s_q;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    retry_q, retry_d;
  logic          lock_lost_q, lock_lost_d;
  logic          pll_rst_q, pll_rst_d;
  logic          core_reset_q, core_reset_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          timeout;

  assign timeout = ((state_q == S_WAIT) || (state_q == S_STABLE)) &&
                   (tmo_q == TW'(LOCK_TIMEOUT - 1));

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= S_PULSE;
      sync1_q      <= 1'b0;
      locked_s_q   <= 1'b0;
      pulse_cnt_q  <= '0;
      tmo_q        <= '0;
      stable_q     <= '0;
      hold_q       <= '0;
      retry_q      <= '0;
      lock_lost_q  <= 1'b0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= pll_locked;
      locked_s_q   <= sync1_q;
      pulse_cnt_q  <= pulse_cnt_d;
      tmo_q        <= tmo_d;
      stable_q     <= stable_d;
      hold_q       <= hold_d;
      retry_q      <= retry_d;
      lock_lost_q  <= lock_lost_d;
      pll_rst_q    <= pll_rst_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  // pulse_cnt counts pll_rst-high cycles after reset release; a re-entry into
  // PULSE counts its own entry cycle, so every pulse is RST_PULSE cycles long.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    tmo_d       = tmo_q;
    stable_d    = stable_q;
    hold_d      = hold_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    if (timeout) begin
      if (retry_q == 4'(MAX_RETRIES)) begin
        state_d = S_FAULT;
      end else begin
        retry_d     = retry_q + 4'd1;
        state_d     = S_PULSE;
        pulse_cnt_d = PW'(1);
      end
    end else begin
      case (state_q)
        S_PULSE: begin
          if (pulse_cnt_q == PW'(RST_PULSE)) begin
            state_d = S_WAIT;
            tmo_d   = '0;
          end else begin
            pulse_cnt_d = pulse_cnt_q + PW'(1);
          end
        end
        S_WAIT: begin
          tmo_d = tmo_q + TW'(1);
          if (locked_s_q) begin
            state_d  = S_STABLE;
            stable_d = '0;
          end
        end
        S_STABLE: begin
          tmo_d = tmo_q + TW'(1);
          if (!locked_s_q) begin
            state_d = S_WAIT;
          end else if (stable_q == SW'(LOCK_STABLE - 1)) begin
            state_d = S_HOLD;
            hold_d  = '0;
          end else begin
            stable_d = stable_q + SW'(1);
          end
        end
        S_HOLD: begin
          if (!locked_s_q) begin
            state_d     = S_PULSE;
            pulse_cnt_d = PW'(1);
          end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            state_d = S_RUN;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            state_d     = S_PULSE;
            pulse_cnt_d = PW'(1);
            retry_d     = '0;
            lock_lost_d = 1'b1;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d     = S_PULSE;
          pulse_cnt_d = PW'(1);
        end
      endcase
    end
  end

  // Decoded from the next state so each output moves on the same edge as the state.
  always_comb begin
    pll_rst_d    = (state_d == S_PULSE);
    core_reset_d = (state_d != S_RUN);
    ready_d      = (state_d == S_RUN);
    fault_d      = (state_d == S_FAULT);
  end

  assign pll_rst     = pll_rst_q;
  assign core_reset  = core_reset_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomized bench for pll_lock_supervisor against a timestamp-based
// reference model of the bring-up sequence.
module tb_pll_lock_supervisor;
  localparam int RP = 4;
  localparam int LT = 32;
  localparam int LS = 8;
  localparam int HC = 16;
  localparam int MR = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, core_reset, ready, fault, lock_lost;
  logic [3:0] retry_count;

  pll_lock_supervisor #(
    .RST_PULSE(RP), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS),
    .HOLD_CYCLES(HC), .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .core_reset(core_reset), .ready(ready),
    .fault(fault), .lock_lost(lock_lost), .retry_count(retry_count)
  );

  always #10 refclk = ~refclk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: phases with absolute edge deadlines.
  localparam int M_PULSE = 0, M_WAIT = 1, M_DEB = 2, M_HOLD = 3, M_RUN = 4, M_FAULT = 5;
  int         now = 0;
  int         rel = 0;
  int         m_phase = M_PULSE;
  int         t_pulse_end = 0, t_timeout = 0, t_deb = 0, t_hold = 0;
  int         m_rc = 0;
  logic       m_ll = 1'b0;
  logic [1:0] m_dly = 2'b00;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: got %0h expected %0h", tag, rel, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {3'b000, obs}, {3'b000, exp});
  endtask

  task automatic restart_pulse();
    m_phase     = M_PULSE;
    t_pulse_end = now + RP;
  endtask

  task automatic give_up_or_retry();
    if (m_rc == MR) m_phase = M_FAULT;
    else begin
      m_rc++;
      restart_pulse();
    end
  endtask

  task automatic model_edge(input logic r, input logic lk);
    logic ls;
    ls = m_dly[1];
    if (r) begin
      m_phase     = M_PULSE;
      t_pulse_end = now + 1 + RP;
      m_rc        = 0;
      m_ll        = 1'b0;
      m_dly       = 2'b00;
      rel         = -1;
    end else begin
      rel++;
      case (m_phase)
        M_PULSE: if (now == t_pulse_end) begin
          m_phase   = M_WAIT;
          t_timeout = now + LT;
        end
        M_WAIT: begin
          if (now == t_timeout) give_up_or_retry();
          else if (ls) begin
            m_phase = M_DEB;
            t_deb   = now;
          end
        end
        M_DEB: begin
          if (now == t_timeout) give_up_or_retry();
          else if (!ls) m_phase = M_WAIT;
          else if (now == t_deb + LS) begin
            m_phase = M_HOLD;
            t_hold  = now;
          end
        end
        M_HOLD: begin
          if (!ls) restart_pulse();
          else if (now == t_hold + HC) m_phase = M_RUN;
        end
        M_RUN: if (!ls) begin
          m_ll = 1'b1;
          m_rc = 0;
          restart_pulse();
        end
        default: ;
      endcase
      m_dly = {m_dly[0], lk};
    end
    now++;
  endtask

  task automatic check_model();
    chk1("m_pll_rst", pll_rst, m_phase == M_PULSE);
    chk1("m_core_reset", core_reset, m_phase != M_RUN);
    chk1("m_ready", ready, m_phase == M_RUN);
    chk1("m_fault", fault, m_phase == M_FAULT);
    chk1("m_lock_lost", lock_lost, m_ll);
    chk("m_retry_count", retry_count, 4'(m_rc));
  endtask

  task automatic tick(input logic r, input logic lk);
    rst        = r;
    pll_locked = lk;
    @(posedge refclk);
    model_edge(r, lk);
    #1;
    check_model();
  endtask

  task automatic chk_reset_values(input string tag);
    chk1({tag, "_pll_rst"}, pll_rst, 1'b1);
    chk1({tag, "_core_reset"}, core_reset, 1'b1);
    chk1({tag, "_ready"}, ready, 1'b0);
    chk1({tag, "_fault"}, fault, 1'b0);
    chk1({tag, "_lock_lost"}, lock_lost, 1'b0);
    chk({tag, "_retry"}, retry_count, 4'd0);
  endtask

  int   seg;
  logic lvl;

  initial begin
    repeat (3) tick(1'b1, 1'b0);
    chk_reset_values("rst");

    // Clean bring-up, loss in RUN at edge 61, relock from edge 66.
    for (int c = 0; c <= 100; c++) begin
      tick(1'b0, (c >= 10 && c <= 60) || c >= 66);
      if (c <= 5) chk1("bring_pll_rst", pll_rst, c <= 3);
      if (c == 35 || c == 36) begin
        chk1("bring_ready", ready, c == 36);
        chk1("bring_core_reset", core_reset, c != 36);
        chk("bring_retry", retry_count, 4'd0);
      end
      if (c == 62 || c == 63) begin
        chk1("loss_ready", ready, c == 62);
        chk1("loss_pll_rst", pll_rst, c == 63);
        chk1("loss_lock_lost", lock_lost, c == 63);
        chk1("loss_core_reset", core_reset, c == 63);
      end
      if (c == 91 || c == 92) chk1("relock_ready", ready, c == 92);
      if (c == 100) chk1("relock_lock_lost", lock_lost, 1'b1);
    end

    // Never locks.
    tick(1'b1, 1'b0);
    for (int c = 0; c <= 115; c++) begin
      tick(1'b0, 1'b0);
      if (c == 3 || c == 4 || c == 35 || c == 36 || c == 39 || c == 40 ||
          c == 71 || c == 72 || c == 75 || c == 76)
        chk1("nolock_pll_rst", pll_rst,
             (c <= 3) || (c >= 36 && c <= 39) || (c >= 72 && c <= 75));
      if (c == 40) chk("nolock_retry1", retry_count, 4'd1);
      if (c == 107) chk("nolock_retry2", retry_count, 4'd2);
      if (c == 107 || c == 108 || c == 115) chk1("nolock_fault", fault, c >= 108);
      if (c == 115) begin
        chk1("nolock_core_reset", core_reset, 1'b1);
        chk("nolock_retry_end", retry_count, 4'd2);
      end
    end
    tick(1'b1, 1'b0);
    chk_reset_values("fault_rst");

    // Debounce: high 5 samples, low 1, then high.
    for (int c = 0; c <= 45; c++) begin
      tick(1'b0, (c >= 10 && c <= 14) || c >= 16);
      if (c == 36 || c == 41 || c == 42) chk1("deb_ready", ready, c == 42);
      if (c == 45) chk("deb_retry", retry_count, 4'd0);
    end

    // One failed attempt, then lock lost during HOLD.
    tick(1'b1, 1'b0);
    for (int c = 0; c <= 90; c++) begin
      tick(1'b0, (c >= 41 && c <= 54) || c >= 58);
      if (c == 56 || c == 57) begin
        chk1("hold_pll_rst", pll_rst, c == 57);
        chk1("hold_core_reset", core_reset, 1'b1);
        chk1("hold_lock_lost", lock_lost, 1'b0);
        chk("hold_retry", retry_count, 4'd1);
      end
      if (c == 85 || c == 86) chk1("hold_relock_ready", ready, c == 86);
    end

    // Reset while debouncing.
    tick(1'b1, 1'b0);
    for (int c = 0; c <= 14; c++) tick(1'b0, c >= 10);
    tick(1'b1, 1'b1);
    chk_reset_values("stable_rst");
    for (int c = 0; c <= 30; c++) begin
      tick(1'b0, 1'b1);
      if (c <= 5) chk1("restart_pll_rst", pll_rst, c <= 3);
      if (c == 28 || c == 29) chk1("restart_ready", ready, c == 29);
    end

    // Randomized segments of lock/unlock with occasional resets.
    seg = 0;
    lvl = 1'b0;
    for (int round = 0; round < 6; round++) begin
      tick(1'b1, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 250; c++) begin
        if (seg == 0) begin
          lvl = ($urandom_range(0, 3) != 0);
          seg = $urandom_range(1, 40);
        end
        tick($urandom_range(0, 299) == 0, lvl);
        seg--;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
